exu_fpu_obuf: RTL
=================

EXU_FPU_OBUF -- requirements
Module: exu_fpu_obuf

Interface
REQ-001 Parameter DATA_W, default 64, result data width (FREG_DATA_WIDTH).
REQ-002 Parameter ADDR_W, default 5, register write-address width.
REQ-003 Parameter CID_W, default 3, commit-id width.
REQ-004 Parameter DEPTH, default 4, maximum outstanding FPU operations; power of two, 2..16.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 req_i  input  1  issue request from the dispatch stage.
REQ-008 fflags_op_i  input  1  the issued op updates FFLAGS (arith, cmp, max, cvt, fma); 0 for sgnj, mv, class.
REQ-009 reg_waddr_i  input  ADDR_W  destination register of the issued op.
REQ-010 commit_id_i  input  CID_W  commit id of the issued op.
REQ-011 stall_o  output  1  req_i is high and cannot be accepted this cycle.
REQ-012 core_req_o  output  1  accepted issue, forwarded to the FPU core enable.
REQ-013 core_ready_i  input  1  one-cycle result pulse from the FPU core; results return in issue order.
REQ-014 core_result_i  input  DATA_W  result data, valid with core_ready_i.
REQ-015 core_flags_i  input  5  exception flags, valid with core_ready_i.
REQ-016 wb_ready_i  input  1  writeback accepts the presented result.
REQ-017 reg_we_o, reg_waddr_o, reg_wdata_o, commit_id_o  outputs  1/ADDR_W/DATA_W/CID_W  head result presented to writeback.
REQ-018 fcsr_we_o  output  1; fcsr_fflags_o  output  5  FFLAGS update for the head result.
REQ-019 fflags_pending_o  output  1  at least one accepted, not yet written-back op has fflags_op=1.
REQ-020 err_o  output  1  sticky protocol-error flag.

Function
REQ-021 Tag FIFO (DEPTH entries: waddr, commit_id, fflags_op) shall be pushed on accept; result FIFO (DEPTH entries: data, flags) shall be pushed on core_ready_i.
REQ-022 Outstanding count OC (0..DEPTH) shall increment on accept and decrement on writeback handshake; simultaneous accept and handshake leave OC unchanged.
REQ-023 Accept = req_i & (OC < DEPTH); core_req_o = accept; stall_o = req_i & (OC == DEPTH); a same-cycle handshake shall not relieve a full stall (no wb_ready_i-to-stall_o path).
REQ-024 In-core count IC = accepted ops without a returned result; core_ready_i with IC == 0 shall be ignored (no push) and shall set err_o.
REQ-025 reg_we_o shall be 1 exactly when the result FIFO is non-empty; reg_wdata_o/fcsr_fflags_o from result-FIFO head, reg_waddr_o/commit_id_o from tag-FIFO head.
REQ-026 Latency: a result pushed at edge N shall appear on reg_we_o after edge N (registered, no combinational core-to-output bypass).
REQ-027 Writeback handshake = reg_we_o & wb_ready_i; on it both FIFOs pop together; outputs hold stable while reg_we_o=1 and wb_ready_i=0.
REQ-028 fcsr_we_o = reg_we_o & head fflags_op & (fcsr_fflags_o != 0).
REQ-029 fflags_pending_o shall be driven from a counter of outstanding fflags_op=1 entries, incremented on accept, decremented on handshake of such an entry; high from the cycle after accept until the cycle after its handshake.
REQ-030 FIFO pointers shall be log2(DEPTH) bits and wrap modulo DEPTH; full/empty shall be distinguished by the counts, not the pointers.
REQ-031 Simultaneous core_ready_i push and handshake pop on the result FIFO shall both take effect, including when it holds DEPTH-1 or 1 entries.
REQ-032 Result FIFO overflow is impossible by construction (entries <= OC <= DEPTH); no overflow check is required.

Reset
REQ-033 On rst=1 at a clock edge: OC, IC, fflags counter, all pointers and err_o shall be 0; reg_we_o, fcsr_we_o, fflags_pending_o, stall_o (if req_i=0), core_req_o shall be 0; data/address/commit_id/flags outputs shall be 0.
REQ-034 Reset mid-operation shall discard all outstanding entries; core_ready_i pulses in the first cycle after reset shall set err_o (the FPU core shall be reset together with this block).

Verification
REQ-035 Single op: accept waddr=3, cid=1, fflags_op=1; core_ready_i 5 cycles later with data=0x3FF0_0000_0000_0000, flags=0x01; wb_ready_i=1 -> reg_we_o=1 one cycle after the pulse, fcsr_we_o=1, fflags=0x01; fflags_pending_o falls one cycle after the handshake.
REQ-036 Fill: DEPTH=4, issue 5 back-to-back with wb_ready_i=0 -> 4 core_req_o pulses, stall_o=1 on the 5th; one handshake -> 5th accepted on the following cycle.
REQ-037 Ordering/wrap: 10 ops with random core delays and random wb_ready_i -> writeback order and waddr/cid pairing match issue order across pointer wrap.
REQ-038 Non-fflags op (fsgnj) with core_flags_i=0x10 -> reg_we_o=1, fcsr_we_o=0; fflags_pending_o stays 0.
REQ-039 Spurious core_ready_i with no op in flight -> no reg_we_o, err_o=1 until rst.
REQ-040 rst asserted with 3 results buffered and wb_ready_i=0 -> next cycle reg_we_o=0, stall_o=0, fflags_pending_o=0.

Source files
------------

// File: rtl/exu_fpu_obuf.sv
// Output buffer between the FPU core and writeback: keeps issue-order tags,
// buffers returned results and drives register/FCSR writeback in order.
module exu_fpu_obuf #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5,
    parameter int CID_W  = 3,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_i,
    input  logic              fflags_op_i,
    input  logic [ADDR_W-1:0] reg_waddr_i,
    input  logic [CID_W-1:0]  commit_id_i,
    output logic              stall_o,
    output logic              core_req_o,
    input  logic              core_ready_i,
    input  logic [DATA_W-1:0] core_result_i,
    input  logic [4:0]        core_flags_i,
    input  logic              wb_ready_i,
    output logic              reg_we_o,
    output logic [ADDR_W-1:0] reg_waddr_o,
    output logic [DATA_W-1:0] reg_wdata_o,
    output logic [CID_W-1:0]  commit_id_o,
    output logic              fcsr_we_o,
    output logic [4:0]        fcsr_fflags_o,
    output logic              fflags_pending_o,
    output logic              err_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_C   = CW'(1);
    localparam logic [CW-1:0] ZERO_C  = CW'(0);
    localparam logic [PW-1:0] PONE_C  = PW'(1);

    logic [ADDR_W-1:0] tag_waddr_r [DEPTH];
    logic [CID_W-1:0]  tag_cid_r   [DEPTH];
    logic              tag_fop_r   [DEPTH];
    logic [DATA_W-1:0] res_data_r  [DEPTH];
    logic [4:0]        res_flags_r [DEPTH];

    logic [PW-1:0] tag_wr_r, res_wr_r, rd_r;
    logic [CW-1:0] oc_r, ic_r, rc_r, fc_r;
    logic [CW-1:0] oc_nxt_s, ic_nxt_s, rc_nxt_s, fc_nxt_s;
    logic          err_r;
    logic          accept_s, push_s, hs_s, head_fop_s, acc_f_s, pop_f_s;

    // Handshake qualifiers; stall is decided only by the registered count.
    always_comb begin
        accept_s   = req_i & (oc_r < DEPTH_C);
        stall_o    = req_i & (oc_r == DEPTH_C);
        core_req_o = accept_s;
        push_s     = core_ready_i & (ic_r != ZERO_C);
        reg_we_o   = (rc_r != ZERO_C);
        hs_s       = reg_we_o & wb_ready_i;
        head_fop_s = tag_fop_r[rd_r];
        acc_f_s    = accept_s & fflags_op_i;
        pop_f_s    = hs_s & head_fop_s;
    end

    // Next values of the outstanding, in-core, result and fflags counters.
    always_comb begin
        oc_nxt_s = oc_r;
        ic_nxt_s = ic_r;
        rc_nxt_s = rc_r;
        fc_nxt_s = fc_r;
        case ({accept_s, hs_s})
            2'b10:   oc_nxt_s = oc_r + ONE_C;
            2'b01:   oc_nxt_s = oc_r - ONE_C;
            default: oc_nxt_s = oc_r;
        endcase
        case ({accept_s, push_s})
            2'b10:   ic_nxt_s = ic_r + ONE_C;
            2'b01:   ic_nxt_s = ic_r - ONE_C;
            default: ic_nxt_s = ic_r;
        endcase
        case ({push_s, hs_s})
            2'b10:   rc_nxt_s = rc_r + ONE_C;
            2'b01:   rc_nxt_s = rc_r - ONE_C;
            default: rc_nxt_s = rc_r;
        endcase
        case ({acc_f_s, pop_f_s})
            2'b10:   fc_nxt_s = fc_r + ONE_C;
            2'b01:   fc_nxt_s = fc_r - ONE_C;
            default: fc_nxt_s = fc_r;
        endcase
    end

    // Counters, pointers and the sticky error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            oc_r     <= ZERO_C;
            ic_r     <= ZERO_C;
            rc_r     <= ZERO_C;
            fc_r     <= ZERO_C;
            tag_wr_r <= '0;
            res_wr_r <= '0;
            rd_r     <= '0;
            err_r    <= 1'b0;
        end else begin
            oc_r  <= oc_nxt_s;
            ic_r  <= ic_nxt_s;
            rc_r  <= rc_nxt_s;
            fc_r  <= fc_nxt_s;
            err_r <= err_r | (core_ready_i & (ic_r == ZERO_C));
            if (accept_s) tag_wr_r <= tag_wr_r + PONE_C;
            if (push_s)   res_wr_r <= res_wr_r + PONE_C;
            if (hs_s)     rd_r     <= rd_r + PONE_C;
        end
    end

    // Entry storage needs no reset: contents are only visible behind the counts.
    always_ff @(posedge clk) begin
        if (accept_s) begin
            tag_waddr_r[tag_wr_r] <= reg_waddr_i;
            tag_cid_r[tag_wr_r]   <= commit_id_i;
            tag_fop_r[tag_wr_r]   <= fflags_op_i;
        end
        if (push_s) begin
            res_data_r[res_wr_r]  <= core_result_i;
            res_flags_r[res_wr_r] <= core_flags_i;
        end
    end

    // Head presentation, forced to zero while nothing is buffered.
    always_comb begin
        if (reg_we_o) begin
            reg_waddr_o   = tag_waddr_r[rd_r];
            commit_id_o   = tag_cid_r[rd_r];
            reg_wdata_o   = res_data_r[rd_r];
            fcsr_fflags_o = res_flags_r[rd_r];
            fcsr_we_o     = head_fop_s & (res_flags_r[rd_r] != 5'd0);
        end else begin
            reg_waddr_o   = '0;
            commit_id_o   = '0;
            reg_wdata_o   = '0;
            fcsr_fflags_o = 5'd0;
            fcsr_we_o     = 1'b0;
        end
        fflags_pending_o = (fc_r != ZERO_C);
        err_o            = err_r;
    end

endmodule
